mem_port_arbiter: RTL and testbench

- Shares the single memory port between the instruction-fetch path and the data cache's refill/write-back path.
- Sequences multi-cycle memory accesses with a latency counter and arbitrates round-robin on contention.
- Returns read data and a one-cycle ready pulse to the winning requester.
- Sits between the core/cache and the memory model; stops issuing new accesses once the core halts.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: lets the instruction-fetch path and the data cache share
// one memory port. A grant is followed by MEM_LATENCY access cycles, then a
// one-cycle ready pulse. Simultaneous requests are served round-robin.
//
// Handshake: a requester raises req and holds it, along with its address
// and data, until its ready pulse. Ready is high for exactly one cycle, and
// read data is valid in that cycle. Requests are sampled only in IDLE.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 4,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halted,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [0:3][7:0]   mem_data_in,
    input  logic [0:3][7:0]   mem_data_out,
    output logic              mem_write_en,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              last_d_q, last_d_d;   // 1 = last grant went to D
    logic              gnt_d_q, gnt_d_d;     // current grantee is D
    logic              is_wr_q, is_wr_d;     // current access is a write
    logic              if_ready_q, if_ready_d;
    logic              d_ready_q, d_ready_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;

    logic grant_d_sel;
    logic grant_i_sel;

    // Round-robin choice: on a tie, grant whichever side did not win last.
    always_comb begin
        grant_d_sel = d_req && (!if_req || !last_d_q);
        grant_i_sel = if_req && !grant_d_sel;
    end

    // Next-state logic for the IDLE/ACCESS/RESP sequencer and its outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d_d   = last_d_q;
        gnt_d_d    = gnt_d_q;
        is_wr_d    = is_wr_q;
        if_ready_d = 1'b0;
        d_ready_d  = 1'b0;
        we_d       = 1'b0;
        busy_d     = busy_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (!halted && (grant_d_sel || grant_i_sel)) begin
                    state_d  = S_ACCESS;
                    cnt_d    = CNT_INIT;
                    busy_d   = 1'b1;
                    gnt_d_d  = grant_d_sel;
                    last_d_d = grant_d_sel;
                    is_wr_d  = grant_d_sel && d_we;
                    addr_d   = grant_d_sel ? d_addr : if_addr;
                    if (grant_d_sel && d_we) begin
                        wdata_d = d_wdata;
                    end
                    // A single-cycle access strobes in its only ACCESS cycle.
                    we_d = grant_d_sel && d_we && (MEM_LATENCY == 1);
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    if (gnt_d_q) begin
                        d_ready_d = 1'b1;
                        if (!is_wr_q) begin
                            d_rdata_d = mem_data_out;
                        end
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_data_out;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    // Registered strobe lands in the counter == 0 cycle.
                    we_d  = is_wr_q && (cnt_q == CW'(1));
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; reset abandons any access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_d_q   <= 1'b0;
            gnt_d_q    <= 1'b0;
            is_wr_q    <= 1'b0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_d_q   <= last_d_d;
            gnt_d_q    <= gnt_d_d;
            is_wr_q    <= is_wr_d;
            if_ready_q <= if_ready_d;
            d_ready_q  <= d_ready_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign if_ready     = if_ready_q;
    assign if_rdata     = if_rdata_q;
    assign d_ready      = d_ready_q;
    assign d_rdata      = d_rdata_q;
    assign mem_addr     = addr_q;
    assign mem_data_in  = wdata_q;
    assign mem_write_en = we_q;
    assign busy         = busy_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter with MEM_LATENCY = 4: directed steps, a
// scoreboard of expected ready responses and cycle-level port checks.
module tb_mem_port_arbiter;

    logic            clk = 1'b0;
    logic            reset;
    logic            halted;
    logic            if_req;
    logic [31:0]     if_addr;
    logic            if_ready;
    logic [31:0]     if_rdata;
    logic            d_req;
    logic            d_we;
    logic [31:0]     d_addr;
    logic [31:0]     d_wdata;
    logic            d_ready;
    logic [31:0]     d_rdata;
    logic [31:0]     mem_addr;
    logic [0:3][7:0] mem_data_in;
    logic [0:3][7:0] mem_data_out;
    logic            mem_write_en;
    logic            busy;
    logic [1:0]      dbg_state;

    int checks   = 0;
    int failures = 0;

    // Expected ready responses: {is_d, data}.
    logic [32:0] exp_q[$];
    logic [31:0] last_d_rdata;

    mem_port_arbiter #(.MEM_LATENCY(4), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .halted(halted),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_write_en(mem_write_en), .busy(busy), .dbg_state(dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        last_d_rdata = 32'h0;
    endtask

    // One access by the given requester, entered from an IDLE cycle. The
    // requester raises req, holds it through ACCESS and drops it in RESP.
    task automatic do_access(input bit is_d, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input bit halt_mid);
        logic [31:0] exp_data;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        mem_data_out = rdata;
        exp_data = (is_d && we) ? last_d_rdata : rdata;
        if (is_d && !we) last_d_rdata = rdata;
        exp_q.push_back({is_d, exp_data});
        tick();
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("acc_busy_c%0d", k), busy, 1);
            chk($sformatf("acc_state_c%0d", k), dbg_state, 1);
            chk($sformatf("acc_addr_c%0d", k), mem_addr, addr);
            chk($sformatf("acc_we_c%0d", k), mem_write_en, (is_d && we && k == 4));
            chk($sformatf("acc_rdy_c%0d", k), is_d ? d_ready : if_ready, 0);
            if (is_d && we) chk($sformatf("acc_wdata_c%0d", k), mem_data_in, wdata);
            if (halt_mid && k == 2) halted = 1'b1;
            tick();
        end
        chk("resp_rdy", is_d ? d_ready : if_ready, 1);
        chk("resp_other_rdy", is_d ? if_ready : d_ready, 0);
        chk("resp_busy", busy, 1);
        chk("resp_we", mem_write_en, 0);
        if (is_d) d_req = 1'b0; else if_req = 1'b0;
        tick();
        chk("bubble_busy", busy, 0);
        chk("bubble_rdy", is_d ? d_ready : if_ready, 0);
    endtask

    // Scoreboard: every ready pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (!reset && (if_ready || d_ready)) begin
            logic [32:0] e;
            chk("sb_both_ready", {if_ready, d_ready} == 2'b11, 0);
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_ready", {if_ready, d_ready}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_who", d_ready, e[32]);
                chk("sb_data", d_ready ? d_rdata : if_rdata, e[31:0]);
            end
        end
    end

    initial begin
        reset = 1'b1; halted = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_data_out = '0;
        do_reset();

        // Reset state.
        chk("rst_busy", busy, 0);
        chk("rst_state", dbg_state, 0);
        chk("rst_ready", {if_ready, d_ready}, 0);
        chk("rst_we", mem_write_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_data_in, 0);
        chk("rst_rdata", {if_rdata, d_rdata}, 0);

        // Single instruction read, then single data write.
        do_access(1'b0, 1'b0, 32'h40, 32'h0, 32'h8C080004, 1'b0);
        do_access(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 32'h12345678, 1'b0);
        chk("write_keeps_d_rdata", d_rdata, 0);
        chk("write_keeps_if_rdata", if_rdata, 32'h8C080004);

        // First tie after reset goes to D, then I is served after the bubble.
        do_reset();
        if_req = 1'b1; if_addr = 32'h80;
        do_access(1'b1, 1'b0, 32'h200, 32'h0, 32'hA5A5_0001, 1'b0);
        do_access(1'b0, 1'b0, 32'h80, 32'h0, 32'h5A5A_0002, 1'b0);

        // Continuous contention: D, I, D, I with the loser always pending.
        for (int g = 0; g < 4; g++) begin
            if (g % 2 == 0) begin
                if_req = 1'b1; if_addr = 32'h1000 + 32'(g);
                do_access(1'b1, 1'b0, 32'h2000 + 32'(g), 32'h0, $urandom, 1'b0);
            end else begin
                d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000 + 32'(g);
                do_access(1'b0, 1'b0, 32'h1000 + 32'(g - 1), 32'h0, $urandom, 1'b0);
            end
        end
        // The last iteration left d_req pending; withdraw it before it is granted.
        d_req = 1'b0;
        tick();
        chk("contend_idle_busy", busy, 0);

        // Halted in IDLE blocks grants.
        halted = 1'b1; if_req = 1'b1; if_addr = 32'h44;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("halt_idle_busy_c%0d", c), busy, 0);
            tick();
        end
        halted = 1'b0;
        // Halt rising mid-access: access completes, then no more grants.
        do_access(1'b0, 1'b0, 32'h44, 32'h0, 32'hC0DE_0044, 1'b1);
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("halt_after_busy_c%0d", c), busy, 0);
            tick();
        end
        if_req = 1'b0; d_req = 1'b0; halted = 1'b0;

        // Reset during cycle 2 of a write abandons it without d_ready.
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hCAFEF00D;
        tick();
        chk("abort_busy_c1", busy, 1);
        tick();
        reset = 1'b1; d_req = 1'b0;
        tick();
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_state", dbg_state, 0);
        chk("abort_we", mem_write_en, 0);
        chk("abort_ready", {if_ready, d_ready}, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_wdata", mem_data_in, 0);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("abort_no_ready_c%0d", c), {if_ready, d_ready, mem_write_en}, 0);
            tick();
        end
        // Tie after the abort still goes to D: last_grant was reset to I.
        if_req = 1'b1; if_addr = 32'h500;
        do_access(1'b1, 1'b0, 32'h600, 32'h0, 32'h600D_0600, 1'b0);
        if_req = 1'b0;
        tick();
        tick();
        chk("end_busy", busy, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
